// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetch front end.
//   JAL_OP        : RV32I opcode predecoded for early jump following
//   if_state_e    : fetch FSM states (idle / request outstanding / stale request)
//   fetch_entry_t : one buffered fetch, {pc, inst}
package inst_fetcher_pkg;

  localparam logic [6:0] JAL_OP = 7'b1101111;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_WAIT    = 2'd1,
    IF_DISCARD = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_queue.sv
// In-order buffer of fetched {pc, inst} entries.
//   clk, rst          : clock, synchronous active-high reset
//   en                : global enable; everything holds when low
//   push / push_data  : enqueue one entry
//   pop               : dequeue head (ignored when empty)
//   flush             : drop all entries; wins over push and pop
//   head              : registered head entry; holds its last value when empty
//   full, empty, count: occupancy
module inst_queue
  import inst_fetcher_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t        mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0]       cnt, cnt_after_pop, cnt_nxt;
  logic                do_push, do_pop;
  fetch_entry_t        head_nxt;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  always_comb begin
    do_pop        = pop && !empty;
    do_push       = push && (!full || do_pop);
    rd_nxt        = rd_ptr + AW'(do_pop);
    cnt_after_pop = cnt - CW'(do_pop);
    cnt_nxt       = cnt_after_pop + CW'(do_push);
    // If the pop drains the queue, the pushed entry becomes the new head
    // directly; otherwise the next stored entry moves up.
    head_nxt      = (cnt_after_pop == '0) ? push_data : mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (en && !flush && do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      head   <= '0;
    end else if (en) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        wr_ptr <= wr_ptr + AW'(do_push);
        rd_ptr <= rd_nxt;
        cnt    <= cnt_nxt;
        if (cnt_nxt != '0) head <= head_nxt;
      end
    end
  end

endmodule

// File: rtl/inst_fetcher.sv
// Fetch front end: issues word reads, follows JAL targets by predecode,
// buffers returned words and hands them to decode with valid/ready.
//   clk_in, rst_in     : clock, synchronous active-high reset
//   rdy_in             : global enable (freeze when low)
//   ifetch_req/addr    : request to memory controller, held until ifetch_done
//   ifetch_done/data   : completion pulse and returned word
//   inst_out/pc_out    : queue head; valid_out qualifies, ready_in accepts
//   redirect_in/pc     : backend flush and new fetch PC
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        ifetch_req,
  output logic [31:0] ifetch_addr,
  input  logic        ifetch_done,
  input  logic [31:0] ifetch_data,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  input  logic        ready_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  if_state_e     state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   addr_q, addr_nxt;
  logic [31:0]   j_imm, npc;
  logic          push, pop, q_full, q_empty;
  logic [CW-1:0] q_count, occ_next;
  fetch_entry_t  head;

  assign ifetch_req  = (state != IF_IDLE);
  assign ifetch_addr = addr_q;
  assign valid_out   = !q_empty;
  assign inst_out    = head.inst;
  assign pc_out      = head.pc;

  // Predecode: unconditional JAL target, everything else falls through.
  assign j_imm = {{11{ifetch_data[31]}}, ifetch_data[31], ifetch_data[19:12],
                  ifetch_data[20], ifetch_data[30:21], 1'b0};
  assign npc   = addr_q + ((ifetch_data[6:0] == JAL_OP) ? j_imm : 32'd4);

  assign pop      = valid_out && ready_in;
  assign push     = (state == IF_WAIT) && ifetch_done && !redirect_in;
  assign occ_next = q_count + CW'(push) - CW'(pop);

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    addr_nxt     = addr_q;
    if (redirect_in) begin
      fetch_pc_nxt = redirect_pc;
      if (state == IF_IDLE || ifetch_done) begin
        state_nxt = IF_WAIT;
        addr_nxt  = redirect_pc;
      end else begin
        // Request stays on the bus; its data will be thrown away.
        state_nxt = IF_DISCARD;
      end
    end else begin
      case (state)
        IF_IDLE: begin
          // A dequeue this cycle frees a slot in time for the next request.
          if (!q_full || pop) begin
            state_nxt = IF_WAIT;
            addr_nxt  = fetch_pc;
          end
        end
        IF_WAIT: begin
          if (ifetch_done) begin
            fetch_pc_nxt = npc;
            if (occ_next < CW'(QUEUE_DEPTH)) begin
              addr_nxt = npc;
            end else begin
              state_nxt = IF_IDLE;
            end
          end
        end
        IF_DISCARD: begin
          if (ifetch_done) begin
            state_nxt = IF_WAIT;
            addr_nxt  = fetch_pc;
          end
        end
        default: state_nxt = IF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IF_IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
    end else if (rdy_in) begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      addr_q   <= addr_nxt;
    end
  end

  inst_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk_in),
    .rst       (rst_in),
    .en        (rdy_in),
    .push      (push),
    .push_data ('{pc: addr_q, inst: ifetch_data}),
    .pop       (pop),
    .flush     (redirect_in),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

endmodule
